// File: rtl/pspl_cmd_responder.sv
// PL-side responder for the PS-PL command handshake: decodes synchronized commands,
// echoes state on ctrl_out, and sequences core reset, scan load, calc and result readout.
module pspl_cmd_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int SCAN_WORDS = 1,
    parameter int RES_WORDS  = 1,
    parameter int RST_CYCLES = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [7:0]                       ctrl_in,
    output logic [7:0]                       ctrl_out,
    input  logic [DATA_WIDTH-1:0]            data_in,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic [SCAN_WORDS*DATA_WIDTH-1:0] scan_data,
    output logic                             core_rst_n,
    output logic                             calc_start,
    input  logic                             calc_done,
    input  logic [RES_WORDS*DATA_WIDTH-1:0]  result
);

    localparam int SCAN_IDX_W = (SCAN_WORDS > 1) ? $clog2(SCAN_WORDS) : 1;
    localparam int RES_IDX_W  = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
    localparam int CNT_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [7:0] CMD_IDLE       = 8'd0;
    localparam logic [7:0] CMD_RESET      = 8'd1;
    localparam logic [7:0] CMD_CALC       = 8'd2;
    localparam logic [7:0] CMD_SCAN       = 8'd3;
    localparam logic [7:0] CMD_PRINT      = 8'd4;
    localparam logic [7:0] CMD_SCAN_SYNC  = 8'd9;
    localparam logic [7:0] CMD_PRINT_SYNC = 8'd10;

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_RST_SYNC, S_CALC, S_CALC_SYNC,
        S_SCAN, S_SCAN_SYNC, S_PRINT, S_PRINT_SYNC
    } state_e;

    state_e                          state_q, state_d;
    logic [7:0]                      ctrl_s1_q, ctrl_s2_q;
    logic [7:0]                      ctrl_out_q, ctrl_out_d;
    logic [DATA_WIDTH-1:0]           data_out_q, data_out_d;
    logic [SCAN_WORDS*DATA_WIDTH-1:0] scan_data_q, scan_data_d;
    logic [SCAN_IDX_W-1:0]           scan_idx_q, scan_idx_d;
    logic [RES_IDX_W-1:0]            print_idx_q, print_idx_d;
    logic [CNT_W-1:0]                rst_cnt_q, rst_cnt_d;
    logic                            core_rst_n_q, core_rst_n_d;
    logic                            calc_start_q, calc_start_d;
    logic                            entering;
    logic [7:0]                      cmd;

    assign cmd = ctrl_s2_q;

    function automatic logic [7:0] state_code(input state_e s);
        case (s)
            S_RST:        return 8'd1;
            S_RST_SYNC:   return 8'd7;
            S_CALC:       return 8'd2;
            S_CALC_SYNC:  return 8'd8;
            S_SCAN:       return 8'd3;
            S_SCAN_SYNC:  return 8'd9;
            S_PRINT:      return 8'd4;
            S_PRINT_SYNC: return 8'd10;
            default:      return 8'd6;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_s1_q    <= '0;
            ctrl_s2_q    <= '0;
            state_q      <= S_IDLE;
            ctrl_out_q   <= 8'd6;
            data_out_q   <= '0;
            scan_data_q  <= '0;
            scan_idx_q   <= '0;
            print_idx_q  <= '0;
            rst_cnt_q    <= '0;
            core_rst_n_q <= 1'b1;
            calc_start_q <= 1'b0;
        end else begin
            ctrl_s1_q    <= ctrl_in;
            ctrl_s2_q    <= ctrl_s1_q;
            state_q      <= state_d;
            ctrl_out_q   <= ctrl_out_d;
            data_out_q   <= data_out_d;
            scan_data_q  <= scan_data_d;
            scan_idx_q   <= scan_idx_d;
            print_idx_q  <= print_idx_d;
            rst_cnt_q    <= rst_cnt_d;
            core_rst_n_q <= core_rst_n_d;
            calc_start_q <= calc_start_d;
        end
    end

    // NOTE: state_d defaults to state_q before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                case (cmd)
                    CMD_RESET: state_d = S_RST;
                    CMD_CALC:  state_d = S_CALC;
                    CMD_SCAN:  state_d = S_SCAN;
                    CMD_PRINT: state_d = S_PRINT;
                    default:   state_d = S_IDLE;
                endcase
            end
            S_RST:  if (rst_cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = S_RST_SYNC;
            // The first CALC cycle is the start pulse; done only counts after it.
            S_CALC: if (!calc_start_q && calc_done) state_d = S_CALC_SYNC;
            S_SCAN: begin
                if (cmd == CMD_SCAN_SYNC)  state_d = S_SCAN_SYNC;
                else if (cmd == CMD_IDLE)  state_d = S_IDLE;
            end
            S_PRINT: begin
                if (cmd == CMD_PRINT_SYNC) state_d = S_PRINT_SYNC;
                else if (cmd == CMD_IDLE)  state_d = S_IDLE;
            end
            S_RST_SYNC, S_CALC_SYNC, S_SCAN_SYNC, S_PRINT_SYNC:
                if (cmd == CMD_IDLE) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        entering     = (state_d != state_q);
        ctrl_out_d   = state_code(state_d);
        core_rst_n_d = (state_d != S_RST);
        calc_start_d = (state_d == S_CALC) && entering;
        data_out_d   = data_out_q;
        scan_data_d  = scan_data_q;
        scan_idx_d   = scan_idx_q;
        print_idx_d  = print_idx_q;
        rst_cnt_d    = '0;

        if (state_d == S_RST) begin
            if (entering) begin
                scan_data_d = '0;
                scan_idx_d  = '0;
                print_idx_d = '0;
            end else begin
                rst_cnt_d = rst_cnt_q + 1'b1;
            end
        end

        if (state_q == S_SCAN && state_d == S_SCAN_SYNC) begin
            scan_data_d[scan_idx_q*DATA_WIDTH +: DATA_WIDTH] = data_in;
            scan_idx_d = (scan_idx_q == SCAN_IDX_W'(SCAN_WORDS - 1)) ? '0 : scan_idx_q + 1'b1;
        end

        if (state_d == S_PRINT && entering)
            data_out_d = result[print_idx_q*DATA_WIDTH +: DATA_WIDTH];

        if (state_q == S_PRINT && state_d == S_PRINT_SYNC)
            print_idx_d = (print_idx_q == RES_IDX_W'(RES_WORDS - 1)) ? '0 : print_idx_q + 1'b1;
    end

    assign ctrl_out   = ctrl_out_q;
    assign data_out   = data_out_q;
    assign scan_data  = scan_data_q;
    assign core_rst_n = core_rst_n_q;
    assign calc_start = calc_start_q;

endmodule

// File: tb/tb_pspl_cmd_responder.sv
// Self-checking bench: two responders (1-word and 2-word buffers) share the command stream;
// expected ctrl_out transitions and their edge numbers are queued and matched by monitors.
module tb_pspl_cmd_responder;

    typedef struct {
        logic [7:0] ctrl;
        int         cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  ctrl_in = 8'd0;
    logic [31:0] data_in = 32'd0;
    logic        calc_done = 1'b0;

    logic [7:0]  ctrl_out_a, ctrl_out_b;
    logic [31:0] data_out_a, data_out_b;
    logic [31:0] scan_data_a;
    logic [63:0] scan_data_b;
    logic        core_rst_n_a, core_rst_n_b;
    logic        calc_start_a, calc_start_b;
    logic [31:0] result_a = 32'hDEADBEEF;
    logic [63:0] result_b = {32'h0000000B, 32'h0000000A};

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;
    logic [7:0] prev_a = 8'd6;
    logic [7:0] prev_b = 8'd6;

    pspl_cmd_responder dut_a (
        .clock(clock), .reset_n(reset_n), .ctrl_in(ctrl_in), .ctrl_out(ctrl_out_a),
        .data_in(data_in), .data_out(data_out_a), .scan_data(scan_data_a),
        .core_rst_n(core_rst_n_a), .calc_start(calc_start_a), .calc_done(calc_done),
        .result(result_a)
    );

    pspl_cmd_responder #(.SCAN_WORDS(2), .RES_WORDS(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .ctrl_in(ctrl_in), .ctrl_out(ctrl_out_b),
        .data_in(data_in), .data_out(data_out_b), .scan_data(scan_data_b),
        .core_rst_n(core_rst_n_b), .calc_start(calc_start_b), .calc_done(calc_done),
        .result(result_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    task automatic push(input logic [7:0] c, input int at);
        exp_t e;
        e.ctrl = c;
        e.cyc  = at;
        sb_a.push_back(e);
        sb_b.push_back(e);
    endtask

    // Drive a command just after an edge and let it settle through the synchronizer.
    task automatic drive(input logic [7:0] c, input bit chg, input logic [7:0] exp);
        @(posedge clock); #1;
        ctrl_in = c;
        if (chg) push(exp, cyc + 3);
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic scan_once(input logic [31:0] d);
        data_in = d;
        drive(8'd3, 1'b1, 8'd3);
        drive(8'd9, 1'b1, 8'd9);
        drive(8'd0, 1'b1, 8'd6);
    endtask

    task automatic print_once(input logic [31:0] exp_b);
        drive(8'd4, 1'b1, 8'd4);
        check("print_data_a", data_out_a, 32'hDEADBEEF);
        check("print_data_b", data_out_b, exp_b);
        drive(8'd10, 1'b1, 8'd10);
        drive(8'd0, 1'b1, 8'd6);
        check("print_hold_b", data_out_b, exp_b);
    endtask

    always @(negedge clock) begin
        if (reset_n && ctrl_out_a !== prev_a) begin
            if (sb_a.size() == 0) check("sb_a_extra", ctrl_out_a, prev_a);
            else begin
                ea = sb_a.pop_front();
                check("sb_a_ctrl", ctrl_out_a, ea.ctrl);
                check("sb_a_cycle", cyc, ea.cyc);
            end
        end
        prev_a = ctrl_out_a;
    end

    always @(negedge clock) begin
        if (reset_n && ctrl_out_b !== prev_b) begin
            if (sb_b.size() == 0) check("sb_b_extra", ctrl_out_b, prev_b);
            else begin
                eb = sb_b.pop_front();
                check("sb_b_ctrl", ctrl_out_b, eb.ctrl);
                check("sb_b_cycle", cyc, eb.cyc);
            end
        end
        prev_b = ctrl_out_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_a, low_b, start_a, start_b, start_cyc;
        bit seen;

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        check("rst_ctrl_out", ctrl_out_a, 8'd6);
        check("rst_data_out", data_out_a, 32'd0);
        check("rst_scan_data", scan_data_a, 32'd0);
        check("rst_core_rst_n", core_rst_n_a, 1'b1);
        check("rst_calc_start", calc_start_a, 1'b0);

        drive(8'd5, 1'b0, 8'd0);
        check("idle_end", ctrl_out_a, 8'd6);
        drive(8'h7F, 1'b0, 8'd0);
        check("idle_undef", ctrl_out_b, 8'd6);
        drive(8'd0, 1'b0, 8'd0);

        scan_once(32'h5);
        check("scan_a", scan_data_a, 32'h5);
        check("scan_b", scan_data_b, 64'h5);

        // Reset command: RST for four edges, then RST_SYNC while the command is held.
        @(posedge clock); #1;
        ctrl_in = 8'd1;
        push(8'd1, cyc + 3);
        push(8'd7, cyc + 7);
        low_a = 0; low_b = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (!core_rst_n_a) low_a++;
            if (!core_rst_n_b) low_b++;
        end
        check("rst_low_a", low_a, 4);
        check("rst_low_b", low_b, 4);
        check("rst_done_a", core_rst_n_a, 1'b1);
        check("rst_clear_a", scan_data_a, 32'd0);
        check("rst_clear_b", scan_data_b, 64'd0);
        drive(8'd0, 1'b1, 8'd6);

        scan_once(32'h11);
        scan_once(32'h22);
        scan_once(32'h33);
        check("wrap_a", scan_data_a, 32'h33);
        check("wrap_b", scan_data_b, {32'h22, 32'h33});

        // Calc: done arrives seven edges after the start edge; idle mid-calc must not abort.
        @(posedge clock); #1;
        ctrl_in = 8'd2;
        push(8'd2, cyc + 3);
        start_a = 0; start_b = 0; start_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            calc_done = 1'b0;
            if (calc_start_a) begin
                start_a++;
                if (start_cyc < 0) start_cyc = cyc;
            end
            if (calc_start_b) start_b++;
            if (start_cyc >= 0 && cyc == start_cyc + 1) ctrl_in = 8'd0;
            if (start_cyc >= 0 && cyc == start_cyc + 6) begin
                calc_done = 1'b1;
                push(8'd8, cyc + 1);
                push(8'd6, cyc + 2);
            end
        end
        check("calc_pulse_a", start_a, 1);
        check("calc_pulse_b", start_b, 1);

        print_once(32'hA);
        print_once(32'hB);
        print_once(32'hA);
        check("print_keep_a", data_out_a, 32'hDEADBEEF);

        // Asynchronous reset while calc_start is high, then a stray calc_done.
        @(posedge clock); #1;
        ctrl_in = 8'd2;
        push(8'd2, cyc + 3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clock); #1;
            if (calc_start_a) seen = 1'b1;
        end
        check("calc2_start_seen", seen, 1'b1);
        @(negedge clock); #1;
        reset_n = 1'b0;
        ctrl_in = 8'd0;
        #1;
        check("arst_ctrl_a", ctrl_out_a, 8'd6);
        check("arst_ctrl_b", ctrl_out_b, 8'd6);
        check("arst_start_a", calc_start_a, 1'b0);
        check("arst_data_out", data_out_a, 32'd0);
        check("arst_scan_b", scan_data_b, 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1 calc_done = 1'b1;
        @(posedge clock);
        #1 calc_done = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("late_done_a", ctrl_out_a, 8'd6);
        check("late_done_start", calc_start_a, 1'b0);

        check("sb_a_drain", sb_a.size(), 0);
        check("sb_b_drain", sb_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pspl_cmd_responder.md
Name: pspl_cmd_responder

Overview:
PL-side responder for the PS-PL command/handshake interface. It decodes 8-bit commands on ctrl_in and echoes its state on ctrl_out. It moves 32-bit words between the PS (data_in/data_out) and a PL core, and sequences that core's reset, scan-load, calculate and result-readout. It sits between the PS GPIO/AXI registers and the measurement core inside the top-level wrapper.

Parameters:
DATA_WIDTH, 32, width of data_in/data_out and of one buffer word
SCAN_WORDS, 1, number of words in the scan buffer presented to the core
RES_WORDS, 1, number of result words read back through PRINT
RST_CYCLES, 4, number of cycles core_rst_n is held low during RST (minimum 1)

Ports:
clock  in  1  system clock; all logic rising-edge
reset_n  in  1  asynchronous, active-low reset
ctrl_in  in  8  command from PS
ctrl_out  out  8  status/echo to PS
data_in  in  DATA_WIDTH  scan word from PS
data_out  out  DATA_WIDTH  result word to PS
scan_data  out  SCAN_WORDS*DATA_WIDTH  scan buffer to core; word i = bits [i*DATA_WIDTH +: DATA_WIDTH]
core_rst_n  out  1  active-low reset to core
calc_start  out  1  one-cycle start pulse to core
calc_done  in  1  core completion pulse or level
result  in  RES_WORDS*DATA_WIDTH  core result, same word packing as scan_data

Behaviour:
- Command codes: idle=0, reset=1, calc=2, scan=3, print=4, end=5, idle_sync=6, reset_sync=7, calc_sync=8, scan_sync=9, print_sync=10.
- ctrl_in passes through a 2-flop synchronizer. The FSM acts on the synchronized value. ctrl_out is registered on the same edge as the state.
- Latency: ctrl_out updates on the 3rd rising edge after ctrl_in changes.
- data_in is not synchronized. The PS holds it stable before issuing scan_sync.
- Reset (reset_n low): state IDLE, ctrl_out=6, data_out=0, scan_data=0, core_rst_n=1, calc_start=0, scan_idx=0, print_idx=0, RST counter=0.
- States and ctrl_out per state: IDLE=6, RST=1, RST_SYNC=7, CALC=2, CALC_SYNC=8, SCAN=3, SCAN_SYNC=9, PRINT=4, PRINT_SYNC=10.
- IDLE: reset goes to RST, calc to CALC, scan to SCAN, print to PRINT. Any other value (including end and undefined codes) holds IDLE.
- RST: core_rst_n=0 for exactly RST_CYCLES cycles. On entry, scan_data, scan_idx and print_idx are cleared. Then go to RST_SYNC with core_rst_n=1. Commands are ignored until RST_SYNC.
- CALC: calc_start=1 only on the first cycle in CALC. calc_done is sampled from the second cycle onward; done goes to CALC_SYNC. cmd idle in CALC does not abort; the FSM waits for done.
- SCAN: cmd scan_sync writes data_in into scan word[scan_idx], increments scan_idx (wraps from SCAN_WORDS-1 to 0) and goes to SCAN_SYNC. cmd idle in SCAN aborts to IDLE with no capture.
- PRINT: on the entry edge, data_out is loaded with result word[print_idx]. cmd print_sync increments print_idx (wraps at RES_WORDS) and goes to PRINT_SYNC. cmd idle in PRINT aborts to IDLE; data_out keeps its value and print_idx is unchanged.
- *_SYNC states: cmd idle returns to IDLE. Any other value holds the state.
- data_out holds its last value outside PRINT. scan_data changes only on capture or RST.
- Asynchronous reset mid-operation returns everything to reset values immediately, including a deasserted calc_start. A calc in progress is abandoned, and a calc_done arriving later in IDLE is ignored.
- No state is reachable except via the listed transitions. Unused state encodings recover to IDLE.

Test Plan:
1. Reset release, ctrl_in=0 -> ctrl_out=6, data_out=0, scan_data=0, core_rst_n=1. Then ctrl_in=5 (end) or 0x7F -> state stays IDLE, ctrl_out=6.
2. SCAN_WORDS=1: scan, data_in=0x5, scan_sync, idle -> ctrl_out sequence 3, 9, 6 (each change 3 edges after ctrl_in); scan_data=0x5.
3. calc with calc_done pulsed 7 cycles after calc_start -> calc_start high exactly 1 cycle; ctrl_out=2 until done, then 8; idle -> 6.
4. result=0xDEADBEEF: print, print_sync, idle -> ctrl_out 4, 10, 6; data_out=0xDEADBEEF.
5. SCAN_WORDS=2, RES_WORDS=2: scan 0x11, then 0x22, then 0x33 -> word0=0x33, word1=0x22 (wrap). Two print cycles with result={0xB,0xA} -> data_out 0xA, then 0xB. A third print -> 0xA.
6. reset cmd after scan -> core_rst_n low exactly RST_CYCLES=4 cycles, ctrl_out 1 then 7, scan_data=0. Separately, reset_n low during CALC -> immediate ctrl_out=6 and calc_start=0; a later calc_done is ignored.
